// File: rtl/decode_round_driver_pkg.sv
// Shared parameters for the decode round driver: controller stage
// encoding and the driver state encoding.
package decode_round_driver_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE         = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT  = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW         = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE        = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING      = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_WAIT_RESULT,
    S_REPORT
  } drv_state_e;

endpackage

// File: rtl/decode_round_driver_timer.sv
// round_timeout_timer: clear/enable counter that flags the last cycle
// of a CYCLES-long window. Ports: clk, reset_n, clear_i, enable_i, expire_o.
module round_timeout_timer #(
  parameter int CYCLES = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int W = $clog2(CYCLES) + 1;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign expire_o = (cnt_q == W'(CYCLES - 1));

endmodule

// File: rtl/decode_round_driver.sv
// Decode round driver: launches controller rounds, waits for the result
// or a timeout, and holds a report until the host takes it.
// Ports: start_valid/start_ready request, new_round_start launch pulse,
// global_stage/result_valid/iteration_counter/cycle_counter from the
// controller, report_* handshake and payload, stat_* counters.
// Optional: DRIVER_STATS_EN enables the stat_* counters (else tied to 0).
module decode_round_driver
  import decode_round_driver_pkg::*;
#(
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int ROUND_ID_WIDTH          = 16,
  parameter int TIMEOUT_CYCLES          = 4096
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start_valid,
  output logic                               start_ready,
  output logic                               new_round_start,
  input  logic [STAGE_WIDTH-1:0]             global_stage,
  input  logic                               result_valid,
  input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  input  logic [31:0]                        cycle_counter,
  output logic                               report_valid,
  input  logic                               report_ready,
  output logic [ROUND_ID_WIDTH-1:0]          report_round_id,
  output logic [ITERATION_COUNTER_WIDTH-1:0] report_iterations,
  output logic [31:0]                        report_cycles,
  output logic                               report_timeout,
  output logic [31:0]                        stat_rounds,
  output logic [15:0]                        stat_timeouts,
  output logic [ITERATION_COUNTER_WIDTH-1:0] stat_max_iterations
);

  localparam logic [ROUND_ID_WIDTH-1:0] ID_ONE =
    {{(ROUND_ID_WIDTH-1){1'b0}}, 1'b1};

  drv_state_e                         state_q;
  logic                               start_ready_q;
  logic                               new_round_start_q;
  logic                               report_valid_q;
  logic                               report_timeout_q;
  logic [ROUND_ID_WIDTH-1:0]          report_round_id_q;
  logic [ITERATION_COUNTER_WIDTH-1:0] report_iterations_q;
  logic [31:0]                        report_cycles_q;
  logic [ROUND_ID_WIDTH-1:0]          round_id_q;
  logic [ROUND_ID_WIDTH-1:0]          cur_id_q;

  logic stage_idle;
  logic accept;
  logic handshake;
  logic waiting;
  logic done;
  logic expire;

  assign stage_idle = (global_stage == STAGE_IDLE);
  assign accept     = start_valid & start_ready_q;
  assign handshake  = report_valid_q & report_ready;
  assign waiting    = (state_q == S_WAIT_ACK) |
                      (state_q == S_WAIT_RESULT);
  assign done       = (state_q == S_WAIT_RESULT) &
                      result_valid & stage_idle;

  round_timeout_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (state_q == S_LAUNCH),
    .enable_i (waiting),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q             <= S_IDLE;
      start_ready_q       <= 1'b0;
      new_round_start_q   <= 1'b0;
      report_valid_q      <= 1'b0;
      report_timeout_q    <= 1'b0;
      report_round_id_q   <= '0;
      report_iterations_q <= '0;
      report_cycles_q     <= '0;
      round_id_q          <= '0;
      cur_id_q            <= '0;
    end else begin
      new_round_start_q <= 1'b0;
      // Ready next cycle iff we will sit in IDLE then; this also keeps it
      // low during the handshake cycle and until a stuck controller idles.
      start_ready_q <= stage_idle &
                       (((state_q == S_IDLE) & ~accept) | handshake);
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q           <= S_LAUNCH;
            new_round_start_q <= 1'b1;
            cur_id_q          <= round_id_q;
            round_id_q        <= round_id_q + ID_ONE;
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // result_valid may still be stale here, so it is not looked at.
          if (expire) begin
            state_q             <= S_REPORT;
            report_valid_q      <= 1'b1;
            report_timeout_q    <= 1'b1;
            report_round_id_q   <= cur_id_q;
            report_iterations_q <= iteration_counter;
            report_cycles_q     <= cycle_counter;
          end else if (!stage_idle) begin
            state_q <= S_WAIT_RESULT;
          end
        end
        S_WAIT_RESULT: begin
          if (done || expire) begin
            state_q             <= S_REPORT;
            report_valid_q      <= 1'b1;
            report_timeout_q    <= ~done;
            report_round_id_q   <= cur_id_q;
            report_iterations_q <= iteration_counter;
            report_cycles_q     <= cycle_counter;
          end
        end
        S_REPORT: begin
          if (report_ready) begin
            state_q        <= S_IDLE;
            report_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign start_ready       = start_ready_q;
  assign new_round_start   = new_round_start_q;
  assign report_valid      = report_valid_q;
  assign report_timeout    = report_timeout_q;
  assign report_round_id   = report_round_id_q;
  assign report_iterations = report_iterations_q;
  assign report_cycles     = report_cycles_q;

`ifdef DRIVER_STATS_EN
  logic [31:0]                        stat_rounds_q;
  logic [15:0]                        stat_timeouts_q;
  logic [ITERATION_COUNTER_WIDTH-1:0] stat_max_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rounds_q   <= '0;
      stat_timeouts_q <= '0;
      stat_max_q      <= '0;
    end else if (handshake) begin
      if (report_timeout_q) begin
        if (stat_timeouts_q != '1) begin
          stat_timeouts_q <= stat_timeouts_q + 16'd1;
        end
      end else begin
        if (stat_rounds_q != '1) begin
          stat_rounds_q <= stat_rounds_q + 32'd1;
        end
        if (report_iterations_q > stat_max_q) begin
          stat_max_q <= report_iterations_q;
        end
      end
    end
  end

  assign stat_rounds         = stat_rounds_q;
  assign stat_timeouts       = stat_timeouts_q;
  assign stat_max_iterations = stat_max_q;
`else
  assign stat_rounds         = '0;
  assign stat_timeouts       = '0;
  assign stat_max_iterations = '0;
`endif

endmodule

// File: tb/tb_decode_round_driver.sv
// Directed bench for decode_round_driver with a hand-driven controller
// model: normal, stale result, backpressure, timeout, id wrap, reset.
module tb_decode_round_driver;
  import decode_round_driver_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   start_valid;
  logic                   start_ready;
  logic                   new_round_start;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   result_valid;
  logic [7:0]             iteration_counter;
  logic [31:0]            cycle_counter;
  logic                   report_valid;
  logic                   report_ready;
  logic [1:0]             report_round_id;
  logic [7:0]             report_iterations;
  logic [31:0]            report_cycles;
  logic                   report_timeout;
  logic [31:0]            stat_rounds;
  logic [15:0]            stat_timeouts;
  logic [7:0]             stat_max_iterations;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_round_driver #(
    .ITERATION_COUNTER_WIDTH (8),
    .ROUND_ID_WIDTH          (2),
    .TIMEOUT_CYCLES          (8)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start_valid         (start_valid),
    .start_ready         (start_ready),
    .new_round_start     (new_round_start),
    .global_stage        (global_stage),
    .result_valid        (result_valid),
    .iteration_counter   (iteration_counter),
    .cycle_counter       (cycle_counter),
    .report_valid        (report_valid),
    .report_ready        (report_ready),
    .report_round_id     (report_round_id),
    .report_iterations   (report_iterations),
    .report_cycles       (report_cycles),
    .report_timeout      (report_timeout),
    .stat_rounds         (stat_rounds),
    .stat_timeouts       (stat_timeouts),
    .stat_max_iterations (stat_max_iterations)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rv"}, 64'(report_valid), 64'd0);
    check({tag, "_nrs"}, 64'(new_round_start), 64'd0);
    check({tag, "_to"}, 64'(report_timeout), 64'd0);
    check({tag, "_id"}, 64'(report_round_id), 64'd0);
    check({tag, "_it"}, 64'(report_iterations), 64'd0);
    check({tag, "_cy"}, 64'(report_cycles), 64'd0);
    check({tag, "_sr"}, 64'(start_ready), 64'd0);
  endtask

  // One clean round: launch, controller leaves IDLE, then finishes.
  task automatic run_round(input logic [7:0] it,
                           input logic [31:0] cy,
                           input logic [1:0] id);
    check("rr_ready", 64'(start_ready), 64'd1);
    start_valid = 1'b1;
    step();
    check("rr_launch", 64'(new_round_start), 64'd1);
    start_valid  = 1'b0;
    global_stage = STAGE_GROW;
    result_valid = 1'b0;
    step();
    step();
    global_stage      = STAGE_IDLE;
    result_valid      = 1'b1;
    iteration_counter = it;
    cycle_counter     = cy;
    step();
    check("rr_valid", 64'(report_valid), 64'd1);
    check("rr_id", 64'(report_round_id), 64'(id));
    check("rr_it", 64'(report_iterations), 64'(it));
    check("rr_cy", 64'(report_cycles), 64'(cy));
    check("rr_to", 64'(report_timeout), 64'd0);
    report_ready = 1'b1;
    step();
    check("rr_done", 64'(report_valid), 64'd0);
    report_ready = 1'b0;
    result_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n           = 1'b0;
    start_valid       = 1'b0;
    global_stage      = STAGE_IDLE;
    result_valid      = 1'b0;
    iteration_counter = '0;
    cycle_counter     = '0;
    report_ready      = 1'b0;
    step();
    step();
    check_idle_outputs("reset");
    check("stat_r", 64'(stat_rounds), 64'd0);
    check("stat_t", 64'(stat_timeouts), 64'd0);
    check("stat_m", 64'(stat_max_iterations), 64'd0);
    reset_n = 1'b1;
    step();
    check("ready_after_reset", 64'(start_ready), 64'd1);

    // Normal round: 3 iterations, 17 cycles, id 0.
    start_valid = 1'b1;
    step();
    check("n_launch", 64'(new_round_start), 64'd1);
    check("n_ready_low", 64'(start_ready), 64'd0);
    start_valid  = 1'b0;
    global_stage = STAGE_GROW;
    step();
    check("n_pulse_one", 64'(new_round_start), 64'd0);
    step();
    global_stage      = STAGE_IDLE;
    result_valid      = 1'b1;
    iteration_counter = 8'd3;
    cycle_counter     = 32'd17;
    step();
    check("n_valid", 64'(report_valid), 64'd1);
    check("n_id", 64'(report_round_id), 64'd0);
    check("n_it", 64'(report_iterations), 64'd3);
    check("n_cy", 64'(report_cycles), 64'd17);
    check("n_to", 64'(report_timeout), 64'd0);
    check("n_ready_rep", 64'(start_ready), 64'd0);
    report_ready = 1'b1;
    step();
    check("n_done", 64'(report_valid), 64'd0);
    check("n_ready_back", 64'(start_ready), 64'd1);
    report_ready = 1'b0;

    // Stale result_valid left high while the stage is still IDLE.
    start_valid = 1'b1;
    step();
    check("s_launch", 64'(new_round_start), 64'd1);
    start_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("s_stale", 64'(report_valid), 64'd0);
    end
    global_stage = STAGE_GROW;
    result_valid = 1'b0;
    step();
    step();
    check("s_wait", 64'(report_valid), 64'd0);
    global_stage      = STAGE_IDLE;
    result_valid      = 1'b1;
    iteration_counter = 8'd5;
    cycle_counter     = 32'd40;
    step();
    check("s_valid", 64'(report_valid), 64'd1);
    check("s_id", 64'(report_round_id), 64'd1);
    check("s_it", 64'(report_iterations), 64'd5);
    check("s_cy", 64'(report_cycles), 64'd40);

    // Backpressure: payload must hold while a new start waits.
    start_valid       = 1'b1;
    iteration_counter = 8'd77;
    cycle_counter     = 32'd999;
    for (int i = 0; i < 5; i++) begin
      step();
      check("b_valid", 64'(report_valid), 64'd1);
      check("b_id", 64'(report_round_id), 64'd1);
      check("b_it", 64'(report_iterations), 64'd5);
      check("b_cy", 64'(report_cycles), 64'd40);
      check("b_nolaunch", 64'(new_round_start), 64'd0);
    end
    report_ready = 1'b1;
    step();
    check("b_done", 64'(report_valid), 64'd0);
    check("b_no_same", 64'(new_round_start), 64'd0);
    check("b_ready", 64'(start_ready), 64'd1);
    report_ready = 1'b0;
    step();
    check("b_next", 64'(new_round_start), 64'd1);

    // Timeout: controller stuck in MERGE; decided on the 8th wait cycle.
    start_valid       = 1'b0;
    global_stage      = STAGE_MERGE;
    result_valid      = 1'b0;
    iteration_counter = 8'd9;
    cycle_counter     = 32'd100;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t_pending", 64'(report_valid), 64'd0);
    end
    step();
    check("t_valid", 64'(report_valid), 64'd1);
    check("t_to", 64'(report_timeout), 64'd1);
    check("t_id", 64'(report_round_id), 64'd2);
    check("t_it", 64'(report_iterations), 64'd9);
    check("t_cy", 64'(report_cycles), 64'd100);
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    check("t_done", 64'(report_valid), 64'd0);
    check("t_hold0", 64'(start_ready), 64'd0);
    step();
    check("t_hold1", 64'(start_ready), 64'd0);
    global_stage = STAGE_IDLE;
    step();
    check("t_release", 64'(start_ready), 64'd1);

    // Remaining rounds show the 2-bit id wrapping 3 -> 0.
    run_round(8'd1, 32'd11, 2'd3);
    run_round(8'd200, 32'hDEAD_BEEF, 2'd0);

    // Reset asserted while waiting for the result.
    start_valid = 1'b1;
    step();
    check("r_launch", 64'(new_round_start), 64'd1);
    start_valid  = 1'b0;
    global_stage = STAGE_PEELING;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("r_async");
    global_stage      = STAGE_IDLE;
    result_valid      = 1'b1;
    iteration_counter = 8'd4;
    step();
    check("r_in_reset", 64'(report_valid), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("r_no_report", 64'(report_valid), 64'd0);
    end
    check("r_ready", 64'(start_ready), 64'd1);
    result_valid = 1'b0;
    run_round(8'd2, 32'd6, 2'd0);

    check("stat_r_end", 64'(stat_rounds), 64'd0);
    check("stat_t_end", 64'(stat_timeouts), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_round_driver.md
DECODE_ROUND_DRIVER -- requirements
Module: decode_round_driver

Interface
REQ-001 SHALL have parameter ITERATION_COUNTER_WIDTH, default 8, the width of the controller iteration count.
REQ-002 SHALL have parameter ROUND_ID_WIDTH, default 16, the width of the round sequence number.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, the maximum number of cycles from launch to result before the round is abandoned.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start_valid, input, 1 bit: host requests a decoding round.
REQ-007 SHALL have port start_ready, output, 1 bit: the driver can accept a round request.
REQ-008 SHALL have port new_round_start, output, 1 bit: one-cycle launch pulse to the stage controller.
REQ-009 SHALL have port global_stage, input, STAGE_WIDTH bits: the controller's broadcast stage.
REQ-010 SHALL have port result_valid, input, 1 bit: the controller has finished decoding.
REQ-011 SHALL have port iteration_counter, input, ITERATION_COUNTER_WIDTH bits: the controller's grow-iteration count.
REQ-012 SHALL have port cycle_counter, input, 32 bits: the controller's decode cycle count.
REQ-013 SHALL have port report_valid, output, 1 bit, and port report_ready, input, 1 bit: the result report handshake.
REQ-014 SHALL have port report_round_id, output, ROUND_ID_WIDTH bits: sequence number of the reported round.
REQ-015 SHALL have port report_iterations, output, ITERATION_COUNTER_WIDTH bits, and port report_cycles, output, 32 bits: the captured counters.
REQ-016 SHALL have port report_timeout, output, 1 bit: the reported round was abandoned.

Function
REQ-017 SHALL implement the states S_IDLE, S_LAUNCH, S_WAIT_ACK, S_WAIT_RESULT and S_REPORT.
REQ-018 SHALL drive start_ready as a registered signal that is 1 only when the state is S_IDLE and global_stage equals STAGE_IDLE.
REQ-019 SHALL, when start_valid and start_ready are both 1, go to S_LAUNCH and assert new_round_start for exactly the next cycle.
REQ-020 SHALL go from S_LAUNCH to S_WAIT_ACK.
REQ-021 SHALL go from S_WAIT_ACK to S_WAIT_RESULT when global_stage is not STAGE_IDLE, which is the acknowledgement that the controller has cleared result_valid.
REQ-022 SHALL, in S_WAIT_RESULT, when result_valid is 1 and global_stage is STAGE_IDLE, capture iteration_counter and cycle_counter in that cycle, set report_timeout to 0 and go to S_REPORT.
REQ-023 SHALL ignore result_valid in S_WAIT_ACK, so a stale 1 left over from the previous round is never accepted.
REQ-024 SHALL keep a timeout counter that clears on launch and increments in S_WAIT_ACK and S_WAIT_RESULT.
REQ-025 SHALL, when the timeout counter equals TIMEOUT_CYCLES-1 and the round has not completed, capture the counter inputs as they are, set report_timeout to 1 and go to S_REPORT.
REQ-026 SHALL give completion priority over timeout when both occur in the same cycle.
REQ-027 SHALL hold report_valid and every report payload stable in S_REPORT until report_ready is 1, then return to S_IDLE.
REQ-028 SHALL keep start_ready at 0 in any cycle in which a report handshake completes, so the next round is accepted no earlier than the following cycle.
REQ-029 SHALL increment the round id on each accepted start and wrap from all-ones to 0.
REQ-030 SHALL hold start_ready at 0 after a timeout until the controller returns to STAGE_IDLE.

Reset
REQ-031 SHALL on reset_n low set the state to S_IDLE and set start_ready, new_round_start, report_valid, report_timeout, report_round_id, report_iterations, report_cycles, the timeout counter and the round id to 0.
REQ-032 SHALL, when reset is asserted mid-round, discard the round without issuing a report.

Configuration
REQ-033 SHALL, with DRIVER_STATS_EN defined, add outputs stat_rounds (32 bits, completed rounds), stat_timeouts (16 bits, timed-out rounds) and stat_max_iterations (ITERATION_COUNTER_WIDTH bits, largest report_iterations among completed rounds), each updated on the report handshake and saturating at its maximum value.
REQ-034 SHALL, without DRIVER_STATS_EN, keep the stat_* ports present and tie them to 0.

Structure
REQ-035 SHALL take STAGE_* and STAGE_WIDTH from the shared parameters file and place the driver state encoding in the shared package.
REQ-036 SHALL use one sub-module, round_timeout_timer, which holds the clear/enable/expire counter.

Verification
REQ-037 SHALL be verified by a normal round: start is accepted, new_round_start pulses one cycle later, and a model controller finishing after 3 iterations and 17 cycles gives a report of round id 0, iterations 3, cycles 17 and timeout 0.
REQ-038 SHALL be verified by a stale result: result_valid is held at 1 from the prior round, and no report is issued until the stage leaves IDLE and result_valid rises again.
REQ-039 SHALL be verified by a timeout: with TIMEOUT_CYCLES=8 and the controller stuck in STAGE_MERGE, a report with timeout 1 appears 8 cycles after launch.
REQ-040 SHALL be verified by backpressure: report_ready is held at 0 for 5 cycles with the payload unchanged, and the next round is accepted only in the cycle after the report handshake.
REQ-041 SHALL be verified by wrap-around: with ROUND_ID_WIDTH=2, five rounds report ids 0, 1, 2, 3, 0.
REQ-042 SHALL be verified by reset mid-round: reset_n is pulsed low in S_WAIT_RESULT, all outputs go to 0, and no report is issued.
